// File: rtl/fan_pkg.sv
// Shared definitions for the fan countdown timer: state encodings and default timing constants.
package fan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    localparam int DEF_CLK_HZ  = 1000;
    localparam int DEF_MAX_SEC = 60;
    localparam int DEF_TIME_W  = 6;

endpackage

// File: rtl/fan_sec_tick.sv
// One-second prescaler: counts enabled cycles 0..CLK_HZ-1 and flags the wrapping cycle with tick.
module fan_sec_tick
    import fan_pkg::*;
#(
    parameter int CLK_HZ = DEF_CLK_HZ
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;

    // tick is combinational so the owner acts on the same edge the counter wraps
    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fan_timer.sv
// Fan countdown timer: set seconds in IDLE, count down in RUN, pause/resume, signal completion.
// Build option: define FAN_TIMER_AUTO_RELOAD_EN to make DONE return to IDLE by itself after one cycle.
module fan_timer
    import fan_pkg::*;
#(
    parameter int CLK_HZ  = DEF_CLK_HZ,
    parameter int MAX_SEC = DEF_MAX_SEC,
    parameter int TIME_W  = DEF_TIME_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sw,
    input  logic              key_inc,
    input  logic              key_dec,
    input  logic              key_start,
    input  logic              key_pause,
    output logic [1:0]        time_model,
    output logic [TIME_W-1:0] time_left,
    output logic              done_pulse
);

    localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_SEC);
    localparam logic [TIME_W-1:0] ONE_T = TIME_W'(1);

    if (MAX_SEC < 1 || MAX_SEC >= (2 ** TIME_W)) begin : g_bad_param
        $error("fan_timer: MAX_SEC must be in 1 .. 2**TIME_W-1");
    end

    state_t            state, state_nxt;
    logic [TIME_W-1:0] preset, preset_nxt, left_nxt;
    logic              done_nxt;
    logic              tick_en, tick_clr, sec_tick;

    assign time_model = state;
    assign tick_en    = sw && (state == ST_RUN);

    fan_sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en),
        .clr   (tick_clr),
        .tick  (sec_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            time_left  <= '0;
            preset     <= '0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            time_left  <= left_nxt;
            preset     <= preset_nxt;
            done_pulse <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        left_nxt   = time_left;
        preset_nxt = preset;
        done_nxt   = 1'b0;
        tick_clr   = 1'b0;
        if (!sw) begin
            state_nxt  = ST_IDLE;
            left_nxt   = '0;
            preset_nxt = '0;
            tick_clr   = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    // a start press wins over a simultaneous adjust and latches the pre-adjust value
                    if (key_start && time_left != '0) begin
                        preset_nxt = time_left;
                        tick_clr   = 1'b1;
                        state_nxt  = ST_RUN;
                    end else if (key_inc && !key_dec) begin
                        if (time_left < MAX_T) left_nxt = time_left + ONE_T;
                    end else if (key_dec && !key_inc) begin
                        if (time_left != '0) left_nxt = time_left - ONE_T;
                    end
                end
                ST_RUN: begin
                    // reaching zero takes precedence over a pause on the same edge
                    if (sec_tick && time_left != '0) begin
                        left_nxt = time_left - ONE_T;
                    end
                    if (sec_tick && time_left <= ONE_T) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end else if (key_pause) begin
                        state_nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (key_pause || key_start) state_nxt = ST_RUN;
                end
                ST_DONE: begin
`ifdef FAN_TIMER_AUTO_RELOAD_EN
                    state_nxt = ST_IDLE;
                    left_nxt  = preset;
`else
                    if (key_start) begin
                        state_nxt = ST_IDLE;
                        left_nxt  = preset;
                    end
`endif
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fan_timer.sv
// Self-checking bench for fan_timer (CLK_HZ=10, MAX_SEC=60) with an elapsed-time reference model.
module tb_fan_timer;

    localparam int HZ   = 10;
    localparam int MAXS = 60;
    localparam int W    = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sw;
    logic         key_inc, key_dec, key_start, key_pause;
    logic [1:0]   time_model;
    logic [W-1:0] time_left;
    logic         done_pulse;

    int checks   = 0;
    int failures = 0;

    // reference model: mode, value being set, latched preset, enabled run cycles since start
    int m_mode, m_set, m_preset, m_elapsed;
    bit m_done;

    always #5 clk = ~clk;

    fan_timer #(.CLK_HZ(HZ), .MAX_SEC(MAXS), .TIME_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw         (sw),
        .key_inc    (key_inc),
        .key_dec    (key_dec),
        .key_start  (key_start),
        .key_pause  (key_pause),
        .time_model (time_model),
        .time_left  (time_left),
        .done_pulse (done_pulse)
    );

    function automatic int exp_left();
        if (m_mode == 0) return m_set;
        return m_preset - m_elapsed / HZ;
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_set = 0; m_preset = 0; m_elapsed = 0; m_done = 0;
    endfunction

    function automatic void model_step(bit s, bit i, bit d, bit st, bit p);
        if (!rst_n || !s) begin
            model_reset();
            return;
        end
        m_done = 0;
        case (m_mode)
            0: begin
                if (st && m_set > 0) begin
                    m_preset = m_set; m_elapsed = 0; m_mode = 1;
                end else if (i && !d) begin
                    m_set = (m_set < MAXS) ? m_set + 1 : MAXS;
                end else if (d && !i) begin
                    m_set = (m_set > 0) ? m_set - 1 : 0;
                end
            end
            1: begin
                m_elapsed++;
                if (m_elapsed == m_preset * HZ) begin
                    m_mode = 2; m_done = 1;
                end else if (p) begin
                    m_mode = 3;
                end
            end
            3: if (p || st) m_mode = 1;
            2: begin
`ifdef FAN_TIMER_AUTO_RELOAD_EN
                m_mode = 0; m_set = m_preset;
`else
                if (st) begin m_mode = 0; m_set = m_preset; end
`endif
            end
            default: m_mode = 0;
        endcase
    endfunction

    task automatic step(input bit s, input bit i, input bit d, input bit st, input bit p);
        @(negedge clk);
        sw = s; key_inc = i; key_dec = d; key_start = st; key_pause = p;
        @(posedge clk);
        model_step(s, i, d, st, p);
        #1;
        key_inc = 0; key_dec = 0; key_start = 0; key_pause = 0;
    endtask

    task automatic idle_n(input int n);
        repeat (n) step(1, 0, 0, 0, 0);
    endtask

    task automatic set_time(input int n);
        step(0, 0, 0, 0, 0);
        repeat (n) step(1, 1, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 0; sw = 0; key_inc = 0; key_dec = 0; key_start = 0; key_pause = 0;
        model_reset();
        #2;
        checks++; if (time_model !== 2'd0) begin failures++; $display("FAIL reset_mode: got %0d want 0", time_model); end
        checks++; if (time_left !== '0) begin failures++; $display("FAIL reset_left: got %0d want 0", time_left); end
        checks++; if (done_pulse !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b want 0", done_pulse); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_inc_saturate();
        set_time(62);
        checks++; if (time_left !== W'(60)) begin failures++; $display("FAIL inc_sat: got %0d want 60", time_left); end
        step(1, 1, 1, 0, 0);
        checks++; if (time_left !== W'(60)) begin failures++; $display("FAIL inc_dec_same: got %0d want 60", time_left); end
        repeat (3) step(1, 0, 1, 0, 0);
        checks++; if (time_left !== W'(57)) begin failures++; $display("FAIL dec: got %0d want 57", time_left); end
        set_time(1);
        repeat (3) step(1, 0, 1, 0, 0);
        checks++; if (time_left !== W'(0)) begin failures++; $display("FAIL dec_floor: got %0d want 0", time_left); end
    endtask

    task automatic test_countdown();
        set_time(3);
        step(1, 0, 0, 1, 0);
        checks++; if (time_model !== 2'd1) begin failures++; $display("FAIL cd_start_mode: got %0d want 1", time_model); end
        for (int k = 1; k <= 31; k++) begin
            step(1, 0, 0, 0, 0);
            checks++; if (done_pulse !== (k == 30)) begin failures++; $display("FAIL cd_done_k%0d: got %0b want %0b", k, done_pulse, (k == 30)); end
            checks++; if (time_left !== W'(exp_left())) begin failures++; $display("FAIL cd_model_k%0d: got %0d want %0d", k, time_left, exp_left()); end
            if (k == 10 || k == 20 || k == 30) begin
                checks++; if (time_left !== W'(3 - k / 10)) begin failures++; $display("FAIL cd_left_k%0d: got %0d want %0d", k, time_left, 3 - k / 10); end
            end
            if (k == 30) begin
                checks++; if (time_model !== 2'd2) begin failures++; $display("FAIL cd_done_mode: got %0d want 2", time_model); end
            end
        end
    endtask

    task automatic test_done_ack();
        idle_n(5);
        checks++; if (time_model !== 2'd2 || time_left !== '0) begin failures++; $display("FAIL done_hold: got mode %0d left %0d want mode 2 left 0", time_model, time_left); end
        step(1, 1, 0, 0, 1);
        checks++; if (time_model !== 2'd2 || time_left !== '0) begin failures++; $display("FAIL done_ignore: got mode %0d left %0d want mode 2 left 0", time_model, time_left); end
        step(1, 0, 0, 1, 0);
        checks++; if (time_model !== 2'd0 || time_left !== W'(3)) begin failures++; $display("FAIL done_ack: got mode %0d left %0d want mode 0 left 3", time_model, time_left); end
    endtask

    task automatic test_auto_reload();
        set_time(1);
        step(1, 0, 0, 1, 0);
        idle_n(9);
        checks++; if (time_model !== 2'd1) begin failures++; $display("FAIL ar_run: got %0d want 1", time_model); end
        step(1, 0, 0, 0, 0);
        checks++; if (time_model !== 2'd2 || done_pulse !== 1'b1) begin failures++; $display("FAIL ar_done: got mode %0d done %0b want mode 2 done 1", time_model, done_pulse); end
        step(1, 0, 0, 0, 0);
        checks++; if (time_model !== 2'd0 || time_left !== W'(1)) begin failures++; $display("FAIL ar_reload: got mode %0d left %0d want mode 0 left 1", time_model, time_left); end
    endtask

    task automatic test_pause();
        set_time(2);
        step(1, 0, 0, 1, 0);
        idle_n(4);
        step(1, 0, 0, 0, 1);
        checks++; if (time_model !== 2'd3) begin failures++; $display("FAIL pause_enter: got %0d want 3", time_model); end
        repeat (50) step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
        checks++; if (time_model !== 2'd3 || time_left !== W'(2)) begin failures++; $display("FAIL pause_hold: got mode %0d left %0d want mode 3 left 2", time_model, time_left); end
        step(1, 0, 0, 0, 1);
        checks++; if (time_model !== 2'd1) begin failures++; $display("FAIL pause_resume: got %0d want 1", time_model); end
        idle_n(4);
        checks++; if (time_left !== W'(2)) begin failures++; $display("FAIL pause_before_dec: got %0d want 2", time_left); end
        step(1, 0, 0, 0, 0);
        checks++; if (time_left !== W'(1)) begin failures++; $display("FAIL pause_first_dec: got %0d want 1", time_left); end
        checks++; if (time_left !== W'(exp_left())) begin failures++; $display("FAIL pause_model: got %0d want %0d", time_left, exp_left()); end
    endtask

    task automatic test_priority();
        set_time(3);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1);
        checks++; if (time_model !== 2'd3) begin failures++; $display("FAIL prio_run: got %0d want 3", time_model); end
        step(1, 0, 0, 1, 1);
        checks++; if (time_model !== 2'd1) begin failures++; $display("FAIL prio_pause: got %0d want 1", time_model); end
    endtask

    task automatic test_sw_off();
        set_time(7);
        step(1, 0, 0, 1, 0);
        idle_n(5);
        checks++; if (time_left !== W'(7) || time_model !== 2'd1) begin failures++; $display("FAIL sw_pre: got mode %0d left %0d want mode 1 left 7", time_model, time_left); end
        step(0, 1, 0, 1, 1);
        checks++; if (time_model !== 2'd0 || time_left !== '0 || done_pulse !== 1'b0) begin failures++; $display("FAIL sw_off: got mode %0d left %0d done %0b want 0 0 0", time_model, time_left, done_pulse); end
        step(1, 0, 0, 1, 0);
        checks++; if (time_model !== 2'd0 || time_left !== '0) begin failures++; $display("FAIL start_zero: got mode %0d left %0d want mode 0 left 0", time_model, time_left); end
    endtask

    task automatic test_reset_mid_run();
        set_time(2);
        step(1, 0, 0, 1, 0);
        idle_n(15);
        checks++; if (time_left !== W'(1)) begin failures++; $display("FAIL rst_pre: got %0d want 1", time_left); end
        @(negedge clk);
        rst_n = 0;
        #1;
        model_reset();
        checks++; if (time_model !== 2'd0 || time_left !== '0 || done_pulse !== 1'b0) begin failures++; $display("FAIL rst_async: got mode %0d left %0d done %0b want 0 0 0", time_model, time_left, done_pulse); end
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 0, 0, 0);
            checks++; if (done_pulse !== 1'b0 || time_model !== 2'd0) begin failures++; $display("FAIL rst_hold_%0d: got mode %0d done %0b want 0 0", k, time_model, done_pulse); end
        end
        @(negedge clk);
        rst_n = 1;
        idle_n(12);
        checks++; if (time_model !== 2'd0 || time_left !== '0 || done_pulse !== 1'b0) begin failures++; $display("FAIL rst_after: got mode %0d left %0d done %0b want 0 0 0", time_model, time_left, done_pulse); end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 399) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0));
            checks++;
            if (time_model !== 2'(m_mode) || time_left !== W'(exp_left()) || done_pulse !== m_done) begin
                failures++;
                if (bad < 10) $display("FAIL rand_%0d: got mode %0d left %0d done %0b want mode %0d left %0d done %0b",
                                       n, time_model, time_left, done_pulse, m_mode, exp_left(), m_done);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_inc_saturate();
        test_countdown();
`ifdef FAN_TIMER_AUTO_RELOAD_EN
        test_auto_reload();
`else
        test_done_ack();
`endif
        test_pause();
        test_priority();
        test_sw_off();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
